// File: rtl/cdp1802_uart_pkg.sv
// Shared constants for the CDP1802 serial console: I/O port numbers,
// status-byte bit positions and the TX/RX state encodings.
// Imported by the UART top; no logic lives here.
package cdp1802_io_pkg;

  // N-line port numbers decoded by the UART
  localparam logic [2:0] UART_TX   = 3'd1;
  localparam logic [2:0] UART_RX   = 3'd2;
  localparam logic [2:0] UART_STAT = 3'd3;

  // Status byte bit positions (bits 7:5 read as zero)
  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_TX_IDLE    = 1;
  localparam int STAT_RX_VALID   = 2;
  localparam int STAT_RX_OVERRUN = 3;
  localparam int STAT_RX_FERR    = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/cdp1802_uart_if.sv
// CPU-side N-line I/O bus as seen by the UART: port select, strobes, data.
// io_rdata is a combinational return path, valid in the same cycle as io_rd.
// No backpressure: strobes are single-cycle and always accepted by the slave.
interface cdp1802_uart_if;
  logic [2:0] io_n;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;

  modport master (output io_n, output io_wr, output io_rd, output io_wdata, input io_rdata);
  modport slave  (input io_n, input io_wr, input io_rd, input io_wdata, output io_rdata);
endinterface

// File: rtl/cdp1802_uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; dout shows the head entry combinationally.
// Latency: a pushed entry is visible at dout / clears empty one cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the spare MSB makes full/empty distinguishable
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/cdp1802_uart.sv
// 8N1 serial console on the CDP1802 N-line bus: OUT 1 queues TX, INP 2 pops RX, INP 3 status.
// Latency: start bit leaves 2 cycles after OUT 1 on an idle UART; rdata is combinational.
// Backpressure: none on the bus; TX bytes pushed while the FIFO is full are silently dropped.
module cdp1802_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  cdp1802_uart_if.slave        bus,
  input  logic                 rxd,
  output logic                 txd,
  output logic                 irq
);
  import cdp1802_io_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // Bus decode
  logic tx_push, rx_pop, stat_rd;
  assign tx_push = bus.io_wr && (bus.io_n == UART_TX);
  assign rx_pop  = bus.io_rd && (bus.io_n == UART_RX);
  assign stat_rd = bus.io_rd && (bus.io_n == UART_STAT);

  // TX FIFO
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .din   (bus.io_wdata),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // TX state
  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  // RX state
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_armed_q, rx_armed_d;
  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_load, rx_ferr_set;

  // TX framer: STOP pops the next byte in its last cycle so frames run back to back
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        tx_cnt_d = tx_cnt_q + CNT_ONE;
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
          txd_d      = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + CNT_ONE;
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q + CNT_ONE;
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_dout;
            tx_state_d = TX_START;
            txd_d      = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  // RX deframer: arm only after seeing line high, so a held break cannot retrigger
  always_comb begin
    rx_s1_d     = rxd;
    rx_s2_d     = rx_s1_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_armed_d  = rx_armed_q;
    rx_load     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_armed_q) begin
          rx_armed_d = rx_s2_q;
        end else if (!rx_s2_q) begin
          rx_armed_d = 1'b0;
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + CNT_ONE;
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + CNT_ONE;
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + CNT_ONE;
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d    = '0;
          rx_load     = rx_s2_q;
          rx_ferr_set = !rx_s2_q;
          rx_state_d  = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Holding register and sticky flags; a fresh event wins over a same-cycle clear
  always_comb begin
    rx_data_d  = rx_load ? rx_shift_q : rx_data_q;
    rx_valid_d = rx_load ? 1'b1 : (rx_pop ? 1'b0 : rx_valid_q);
    rx_ovr_d   = (rx_load && rx_valid_q && !rx_pop) ? 1'b1 : (stat_rd ? 1'b0 : rx_ovr_q);
    rx_ferr_d  = rx_ferr_set ? 1'b1 : (stat_rd ? 1'b0 : rx_ferr_q);
  end

  // All UART state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_armed_q <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_armed_q <= rx_armed_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // CPU read-back mux: RX byte, status, or zero for unmapped ports
  always_comb begin
    logic [7:0] status;
    status                  = 8'h00;
    status[STAT_TX_FULL]    = fifo_full;
    status[STAT_TX_IDLE]    = fifo_empty && (tx_state_q == TX_IDLE);
    status[STAT_RX_VALID]   = rx_valid_q;
    status[STAT_RX_OVERRUN] = rx_ovr_q;
    status[STAT_RX_FERR]    = rx_ferr_q;
    bus.io_rdata = 8'h00;
    case (bus.io_n)
      UART_RX:   bus.io_rdata = rx_data_q;
      UART_STAT: bus.io_rdata = status;
      default:   bus.io_rdata = 8'h00;
    endcase
  end

  assign txd = txd_q;
  assign irq = rx_valid_q;
endmodule

// File: tb/tb_cdp1802_uart.sv
// Self-checking bench: CPU bus tasks, a serial-line monitor on txd, a serial driver on rxd.
// Expected bytes/status come from the framing rules and a queue of accepted bytes.
// Stimulus bytes are drawn with $urandom.
module tb_cdp1802_uart;
  localparam int CPB = 16;
  localparam int DEPTH = 8;

  logic clock, reset, rxd, txd, irq;
  int   total, bad, cyc;

  cdp1802_uart_if bus();

  cdp1802_uart #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .rxd   (rxd),
    .txd   (txd),
    .irq   (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor results and expected TX bytes
  logic [7:0] mon_q[$];
  logic       mon_ok[$];
  int         mon_start[$];
  logic [7:0] exp_tx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Tasks are entered at a negedge and return at the following negedge
  task automatic cpu_out(input logic [2:0] port, input logic [7:0] d);
    bus.io_n = port; bus.io_wdata = d; bus.io_wr = 1'b1;
    @(negedge clock);
    bus.io_wr = 1'b0; bus.io_n = 3'd0;
  endtask

  task automatic cpu_in(input logic [2:0] port, output logic [7:0] d);
    bus.io_n = port; bus.io_rd = 1'b1;
    #1 d = bus.io_rdata;
    @(negedge clock);
    bus.io_rd = 1'b0; bus.io_n = 3'd0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic stop_v);
    rxd = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clock);
    end
    rxd = stop_v;
    repeat (CPB) @(negedge clock);
    rxd = 1'b1;
  endtask

  task automatic clear_mon();
    mon_q.delete(); mon_ok.delete(); mon_start.delete(); exp_tx.delete();
  endtask

  task automatic check_tx();
    check("tx_count", mon_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < mon_q.size(); i++) begin
      check("tx_byte", mon_q[i], exp_tx[i]);
      check("tx_frame", mon_ok[i], 1);
      if (i > 0) check("tx_gap", mon_start[i] - mon_start[i-1], 10 * CPB);
    end
    clear_mon();
  endtask

  // Serial monitor: every bit must hold for exactly CPB cycles; value taken mid-bit
  initial begin : mon
    logic [9:0] fr;
    logic       first_v, v, stable;
    int         sc;
    forever begin
      @(negedge clock);
      if (txd === 1'b0) begin
        sc = cyc; stable = 1'b1; fr = '0; first_v = 1'b0;
        for (int k = 0; k < 10; k++) begin
          for (int j = 0; j < CPB; j++) begin
            if (!(k == 0 && j == 0)) @(negedge clock);
            v = txd;
            if (j == 0) first_v = v;
            else if (v !== first_v) stable = 1'b0;
            if (j == CPB / 2) fr[k] = v;
          end
        end
        mon_q.push_back(fr[8:1]);
        mon_ok.push_back(stable && !fr[0] && fr[9]);
        mon_start.push_back(sc);
      end
    end
  end

  initial begin
    logic [7:0] s, r, b;
    logic [7:0] rx_exp[$];
    int n;
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; rxd = 1'b1;
    bus.io_n = 3'd0; bus.io_wr = 1'b0; bus.io_rd = 1'b0; bus.io_wdata = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset / idle state
    repeat (100) @(negedge clock);
    check("rst_txd", txd, 1);
    check("rst_irq", irq, 0);
    cpu_in(3'd3, s); check("rst_stat", s, 8'h02);
    cpu_in(3'd5, s); check("unmapped_rd", s, 8'h00);
    cpu_out(3'd2, 8'hFF);
    cpu_in(3'd3, s); check("stray_wr", s, 8'h02);

    // Single byte: latency, framing, return to idle
    clear_mon();
    cpu_out(3'd1, 8'hA5); exp_tx.push_back(8'hA5);
    check("tx_lat1", txd, 1);
    @(negedge clock); check("tx_lat2", txd, 0);
    repeat (10 * CPB - 1) @(negedge clock);
    cpu_in(3'd3, s); check("tx_busy_end", s, 8'h00);
    cpu_in(3'd3, s); check("tx_idle_back", s, 8'h02);
    repeat (5) @(negedge clock);
    check_tx();

    // Back-to-back burst: first byte drains immediately, 9 fit, 10th dropped
    for (int i = 0; i < 9; i++) begin
      cpu_out(3'd1, 8'(i)); exp_tx.push_back(8'(i));
    end
    cpu_in(3'd3, s); check("tx_full", s, 8'h01);
    cpu_out(3'd1, 8'h09);
    repeat (9 * 10 * CPB + 50) @(negedge clock);
    cpu_in(3'd3, s); check("burst_idle", s, 8'h02);
    check_tx();

    // Random bursts
    for (int t = 0; t < 2; t++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        cpu_out(3'd1, b);
        if (i < DEPTH + 1) exp_tx.push_back(b);
      end
      repeat (exp_tx.size() * 10 * CPB + 50) @(negedge clock);
      cpu_in(3'd3, s); check("rnd_idle", s, 8'h02);
      check_tx();
    end

    // RX single byte
    drive_byte(8'h3C, 1'b1);
    repeat (2) @(negedge clock);
    check("rx_irq", irq, 1);
    cpu_in(3'd3, s); check("rx_stat", s, 8'h06);
    cpu_in(3'd2, r); check("rx_byte", r, 8'h3C);
    check("rx_irq_clr", irq, 0);

    // Overrun
    drive_byte(8'h11, 1'b1);
    drive_byte(8'h22, 1'b1);
    repeat (2) @(negedge clock);
    cpu_in(3'd3, s); check("ovr_stat", s, 8'h0E);
    cpu_in(3'd3, s); check("ovr_clr", s, 8'h06);
    cpu_in(3'd2, r); check("ovr_byte", r, 8'h22);
    cpu_in(3'd3, s); check("ovr_after", s, 8'h02);

    // Random RX bytes, each read after arrival
    for (int t = 0; t < 6; t++) begin
      b = 8'($urandom);
      rx_exp.push_back(b);
      drive_byte(b, 1'b1);
      repeat ($urandom_range(2, 20)) @(negedge clock);
      cpu_in(3'd2, r); check("rnd_rx", r, rx_exp.pop_front());
      check("rnd_rx_irq", irq, 0);
    end

    // Framing error
    drive_byte(8'h55, 1'b0);
    repeat (2) @(negedge clock);
    cpu_in(3'd3, s); check("ferr_stat", s, 8'h12);
    check("ferr_irq", irq, 0);
    cpu_in(3'd3, s); check("ferr_clr", s, 8'h02);

    // Short glitch ignored
    rxd = 1'b0; repeat (4) @(negedge clock); rxd = 1'b1;
    repeat (200) @(negedge clock);
    cpu_in(3'd3, s); check("glitch_stat", s, 8'h02);
    check("glitch_irq", irq, 0);

    // Reset mid-frame on both TX and RX
    cpu_out(3'd1, 8'h00);
    rxd = 1'b0;
    repeat (40) @(negedge clock);
    check("mid_txd_low", txd, 0);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_txd", txd, 1);
    reset = 1'b0; rxd = 1'b1;
    repeat (200) @(negedge clock);
    cpu_in(3'd3, s); check("mid_rst_stat", s, 8'h02);
    check("mid_rst_irq", irq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
